// File: rtl/keypad_lcd_main_pkg.sv
// Shared definitions for the keypad + HD44780 LCD board: LCD commands, FSM states,
// keypad position/code tables and code-to-ASCII / code-to-segment conversion.
package keypad_lcd_main_pkg;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;
   localparam logic [7:0] CMD_LINE1    = 8'h80;
   localparam logic [7:0] CMD_LINE2    = 8'hC0;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT
   } lcd_state_t;

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_ON;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

   // r = row from top, c = column from left
   function automatic logic [3:0] key_code_at(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: return 4'h1;
         4'h1: return 4'h2;
         4'h2: return 4'h3;
         4'h3: return 4'hA;
         4'h4: return 4'h4;
         4'h5: return 4'h5;
         4'h6: return 4'h6;
         4'h7: return 4'hB;
         4'h8: return 4'h7;
         4'h9: return 4'h8;
         4'hA: return 4'h9;
         4'hB: return 4'hC;
         4'hC: return 4'hE;
         4'hD: return 4'h0;
         4'hE: return 4'hF;
         default: return 4'hD;
      endcase
   endfunction

   function automatic logic [7:0] key_ascii(input logic [3:0] code);
      if (code <= 4'd9)
         return 8'h30 + {4'h0, code};
      else if (code <= 4'hD)
         return 8'h37 + {4'h0, code};
      else if (code == 4'hE)
         return 8'h2A;
      else
         return 8'h23;
   endfunction

   function automatic logic [6:0] key_seg(input logic [3:0] code);
      case (code)
         4'h0: return 7'h3F;
         4'h1: return 7'h06;
         4'h2: return 7'h5B;
         4'h3: return 7'h4F;
         4'h4: return 7'h66;
         4'h5: return 7'h6D;
         4'h6: return 7'h7D;
         4'h7: return 7'h07;
         4'h8: return 7'h7F;
         4'h9: return 7'h6F;
         4'hA: return 7'h77;
         4'hB: return 7'h7C;
         4'hC: return 7'h39;
         4'hD: return 7'h5E;
         4'hE: return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with full-scan debounce; emits one key_valid pulse per
// accepted press and ignores the keypad until a debounced release is seen.
module keypad_scanner
   import keypad_lcd_main_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int DEB_SCANS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int MW = $clog2(DEB_SCANS + 1);

   logic [DW-1:0] div_cnt;
   logic [1:0]    slot;
   logic          hit_found;
   logic [3:0]    hit_code;
   logic          last_found;
   logic [3:0]    last_code;
   logic [MW-1:0] match_cnt;
   logic          pressed;

   logic          slot_hit;
   logic [1:0]    hit_row;
   logic [3:0]    slot_code;
   logic          scan_found;
   logic [3:0]    scan_code;
   logic          same_scan;
   logic [MW-1:0] match_nxt;
   logic          stable;

   assign col = ~(4'b1000 >> slot);

   always_comb begin
      slot_hit = ~&row;
      hit_row  = 2'd3;
      if (!row[3])
         hit_row = 2'd0;
      else if (!row[2])
         hit_row = 2'd1;
      else if (!row[1])
         hit_row = 2'd2;
      slot_code  = key_code_at(hit_row, slot);
      // earlier (more leftward) columns in the same scan take priority
      scan_found = hit_found | slot_hit;
      scan_code  = hit_found ? hit_code : slot_code;
      same_scan  = (scan_found == last_found) && (!scan_found || scan_code == last_code);
      if (!same_scan)
         match_nxt = MW'(1);
      else if (match_cnt == MW'(DEB_SCANS))
         match_nxt = match_cnt;
      else
         match_nxt = match_cnt + 1'b1;
      stable = (match_nxt == MW'(DEB_SCANS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt    <= DW'(SCAN_DIV - 1);
         slot       <= 2'd0;
         hit_found  <= 1'b0;
         hit_code   <= 4'h0;
         last_found <= 1'b0;
         last_code  <= 4'h0;
         match_cnt  <= '0;
         pressed    <= 1'b0;
         key_valid  <= 1'b0;
         key_code   <= 4'h0;
      end else begin
         key_valid <= 1'b0;
         if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
         end else begin
            div_cnt <= DW'(SCAN_DIV - 1);
            slot    <= slot + 2'd1;
            if (slot == 2'd3) begin
               hit_found  <= 1'b0;
               last_found <= scan_found;
               last_code  <= scan_code;
               match_cnt  <= match_nxt;
               if (stable && scan_found && !pressed) begin
                  key_valid <= 1'b1;
                  key_code  <= scan_code;
                  pressed   <= 1'b1;
               end else if (stable && !scan_found) begin
                  pressed <= 1'b0;
               end
            end else if (!hit_found && slot_hit) begin
               hit_found <= 1'b1;
               hit_code  <= slot_code;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_lcd_main.sv
// Keypad + HD44780 LCD top: scanner instance, 7-seg decode, one-entry pending key and
// the LCD write sequencer (init, cursor line handling, character writes).
//
// state     | meaning
// ST_INIT   | load next of the four power-up commands
// ST_IDLE   | cursor ready; service pending key (line/clear commands first if needed)
// ST_SETUP  | rs/db valid, e low, one clock
// ST_STROBE | e high for E_PULSE clocks
// ST_WAIT   | e low, CMD_WAIT clocks (CLR_WAIT after clear display)
module keypad_lcd_main
   import keypad_lcd_main_pkg::*;
#(
   parameter int SCAN_DIV  = 4,
   parameter int DEB_SCANS = 2,
   parameter int E_PULSE   = 2,
   parameter int CMD_WAIT  = 8,
   parameter int CLR_WAIT  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       rw_out,
   output logic       rs_out,
   output logic       e_out,
   output logic [7:0] db_out,
   output logic [6:0] leds
);

   localparam int WMAX0 = (CLR_WAIT > CMD_WAIT) ? CLR_WAIT : CMD_WAIT;
   localparam int WMAX  = (WMAX0 > E_PULSE) ? WMAX0 : E_PULSE;
   localparam int CW    = $clog2(WMAX + 1);

   logic       key_valid;
   logic [3:0] key_code;

   lcd_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    init_idx, init_idx_n;
   logic          rs_n;
   logic [7:0]    db_n;
   logic [5:0]    pos, pos_n;
   logic          line2_set, line2_n;
   logic          clr_sent, clr_n;
   logic          pend_valid, pend_n;
   logic [3:0]    pend_code, pend_code_n;

   keypad_scanner #(
      .SCAN_DIV  (SCAN_DIV),
      .DEB_SCANS (DEB_SCANS)
   ) u_scanner (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_valid (key_valid),
      .key_code  (key_code)
   );

   assign rw_out = 1'b0;
   assign e_out  = (state == ST_STROBE);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      init_idx_n  = init_idx;
      rs_n        = rs_out;
      db_n        = db_out;
      pos_n       = pos;
      line2_n     = line2_set;
      clr_n       = clr_sent;
      pend_n      = pend_valid;
      pend_code_n = pend_code;
      if (key_valid && !pend_valid) begin
         pend_n      = 1'b1;
         pend_code_n = key_code;
      end
      case (state)
         ST_INIT: begin
            rs_n       = 1'b0;
            db_n       = init_cmd(init_idx[1:0]);
            init_idx_n = init_idx + 3'd1;
            state_n    = ST_SETUP;
         end
         ST_IDLE: begin
            if (pend_valid) begin
               state_n = ST_SETUP;
               // a full display is cleared and re-homed before the character goes out
               if (pos == 6'd32 && !clr_sent) begin
                  rs_n  = 1'b0;
                  db_n  = CMD_CLEAR;
                  clr_n = 1'b1;
               end else if (pos == 6'd32) begin
                  rs_n  = 1'b0;
                  db_n  = CMD_LINE1;
                  clr_n = 1'b0;
                  pos_n = 6'd0;
               end else if (pos == 6'd16 && !line2_set) begin
                  rs_n    = 1'b0;
                  db_n    = CMD_LINE2;
                  line2_n = 1'b1;
               end else begin
                  rs_n        = 1'b1;
                  db_n        = key_ascii(pend_code);
                  pos_n       = pos + 6'd1;
                  line2_n     = 1'b0;
                  pend_n      = key_valid;
                  pend_code_n = key_code;
               end
            end
         end
         ST_SETUP: begin
            state_n = ST_STROBE;
            cnt_n   = CW'(E_PULSE - 1);
         end
         ST_STROBE: begin
            if (cnt == '0) begin
               state_n = ST_WAIT;
               cnt_n   = (!rs_out && db_out == CMD_CLEAR) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         ST_WAIT: begin
            if (cnt == '0)
               state_n = (init_idx == 3'd4) ? ST_IDLE : ST_INIT;
            else
               cnt_n = cnt - 1'b1;
         end
         default: state_n = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_INIT;
         cnt        <= '0;
         init_idx   <= 3'd0;
         rs_out     <= 1'b0;
         db_out     <= 8'h00;
         pos        <= 6'd0;
         line2_set  <= 1'b0;
         clr_sent   <= 1'b0;
         pend_valid <= 1'b0;
         pend_code  <= 4'h0;
         leds       <= 7'h00;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         init_idx   <= init_idx_n;
         rs_out     <= rs_n;
         db_out     <= db_n;
         pos        <= pos_n;
         line2_set  <= line2_n;
         clr_sent   <= clr_n;
         pend_valid <= pend_n;
         pend_code  <= pend_code_n;
         if (key_valid)
            leds <= key_seg(key_code);
      end
   end

endmodule

// File: tb/tb_keypad_lcd_main.sv
// Directed bench for keypad_lcd_main: a behavioural keypad matrix drives row from col,
// and every LCD write is checked against a queue of expected {rs, db} values.
module tb_keypad_lcd_main;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic       rw_out, rs_out, e_out;
   logic [7:0] db_out;
   logic [6:0] leds;

   logic       down [4][4];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         n_pulses = 0;
   int         n_pushed = 0;
   int         pos_m    = 0;
   int         e_len    = 0;
   logic       e_prev   = 1'b0;
   logic [8:0] wr_cur   = 9'h000;
   logic [8:0] exp_q [$];

   string      ascii_tab = "0123456789ABCD*#";
   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   int         key_r [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
   int         key_c [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

   always #5 clk = ~clk;

   keypad_lcd_main dut (
      .clk    (clk),
      .rst    (rst),
      .row    (row),
      .col    (col),
      .rw_out (rw_out),
      .rs_out (rs_out),
      .e_out  (e_out),
      .db_out (db_out),
      .leds   (leds)
   );

   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (down[r][c] && !col[3-c])
               row[3-r] = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic rs, input logic [7:0] db);
      exp_q.push_back({rs, db});
      n_pushed++;
   endtask

   task automatic expect_char(input int code);
      logic [7:0] ch;
      if (pos_m == 16)
         push_wr(1'b0, 8'hC0);
      if (pos_m == 32) begin
         push_wr(1'b0, 8'h01);
         push_wr(1'b0, 8'h80);
         pos_m = 0;
      end
      ch = ascii_tab[code];
      push_wr(1'b1, ch);
      pos_m++;
   endtask

   task automatic release_all();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            down[r][c] = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("lcd_drain", exp_q.size(), 0);
      repeat (50) @(negedge clk);
   endtask

   // a is the key expected to win; b (or -1) is a second key held at the same time
   task automatic press(input int a, input int b, input int scans);
      down[key_r[a]][key_c[a]] = 1'b1;
      if (b >= 0)
         down[key_r[b]][key_c[b]] = 1'b1;
      expect_char(a);
      repeat (scans * 16) @(negedge clk);
      release_all();
      repeat (96) @(negedge clk);
      wait_idle();
      check("leds", leds, seg_tab[a]);
      check("write_count", n_pulses, n_pushed);
   endtask

   always @(negedge clk) begin
      if (e_out && !e_prev) begin
         n_pulses++;
         e_len = 0;
         check("write_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0)
            check("lcd_write", {rs_out, db_out}, exp_q.pop_front());
         check("rw_low", rw_out, 0);
         wr_cur = {rs_out, db_out};
      end
      if (e_out)
         e_len++;
      if (!e_out && e_prev && !rst) begin
         check("e_width", e_len, 2);
         check("bus_hold", {rs_out, db_out}, wr_cur);
      end
      e_prev = e_out;
   end

   initial begin
      int t;
      int base;
      release_all();
      rst = 1'b1;
      repeat (50) @(negedge clk);
      check("rst_col", col, 4'b0111);
      check("rst_e", e_out, 0);
      check("rst_leds", leds, 7'h00);
      check("rst_rs", rs_out, 0);
      check("rst_db", db_out, 8'h00);
      check("rst_no_pulse", n_pulses, 0);

      push_wr(1'b0, 8'h38);
      push_wr(1'b0, 8'h0C);
      push_wr(1'b0, 8'h01);
      push_wr(1'b0, 8'h06);
      rst = 1'b0;
      wait_idle();
      check("init_count", n_pulses, 4);

      press(8, -1, 6);
      press(7, -1, 6);
      press(8, -1, 100);
      press(8, 3, 6);
      press(14, 2, 6);

      for (int i = 0; i < 30; i++)
         press((i * 7 + 3) % 16, -1, 6);

      // reset while e is high
      down[key_r[5]][key_c[5]] = 1'b1;
      expect_char(5);
      t = 0;
      while (!e_out && t < 600) begin
         @(negedge clk);
         t++;
      end
      check("strobe_seen", e_out, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_e", e_out, 0);
      check("mid_rst_col", col, 4'b0111);
      check("mid_rst_leds", leds, 7'h00);
      check("mid_rst_db", db_out, 8'h00);
      check("mid_rst_rs", rs_out, 0);
      release_all();
      exp_q.delete();
      pos_m = 0;
      repeat (20) @(negedge clk);
      base = n_pulses;
      push_wr(1'b0, 8'h38);
      push_wr(1'b0, 8'h0C);
      push_wr(1'b0, 8'h01);
      push_wr(1'b0, 8'h06);
      rst = 1'b0;
      wait_idle();
      check("reinit_count", n_pulses - base, 4);
      press(9, -1, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
